// File: rtl/serial_frame_scheduler_pkg.sv
// Shared constants, state encoding and frame-length helper for the serial frame scheduler.
// Frame layout: 4-bit preamble (MSB first), 4-bit length (MSB first), then len payload bits (LSB first).
// Frame position counter is wide enough for the longest frame (8 + 15 = 23 bits).
package serial_frame_scheduler_pkg;

    localparam int CNT_W     = 4;
    localparam int DATA_W    = 15;
    localparam int FRAME_OVH = 8;
    localparam int POS_W     = 5;
    localparam logic [3:0] PREAMBLE = 4'b1101;

    typedef enum logic [1:0] {IDLE, PRE, CNT, DATA} state_t;

    // Number of valid bits in a frame carrying len payload bits.
    function automatic logic [POS_W-1:0] frame_bits(input logic [CNT_W-1:0] len);
        return POS_W'(FRAME_OVH) + POS_W'(len);
    endfunction

endpackage

// File: rtl/serial_frame_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant from two request levels and a priority pointer.
// Grant is combinational; the pointer moves away from the last winner when update is high.
// Pointer resets to requester 0.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       update,
    input  logic       last,
    output logic [1:0] gnt
);

    logic ptr;

    // Requester 0 wins when alone or when the pointer favours it.
    always_comb begin
        gnt = 2'b00;
        if (req0 && (!req1 || !ptr)) begin
            gnt = 2'b01;
        end else if (req1) begin
            gnt = 2'b10;
        end
    end

    // After a frame completes, priority passes to the requester that did not just win.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (update) begin
            ptr <= ~last;
        end
    end

endmodule

// File: rtl/serial_frame_scheduler.sv
// Round-robin framer: grants one of two requesters and serialises preamble, length and payload.
// One frame bit per clkEn tick; frame of 8+len ticks, then at least one idle tick.
// Requests are levels; they are ignored while busy and sampled only on idle ticks.
module serial_frame_scheduler
    import serial_frame_scheduler_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clkEn,
    input  logic              req0,
    input  logic [CNT_W-1:0]  len0,
    input  logic [DATA_W-1:0] data0,
    input  logic              req1,
    input  logic [CNT_W-1:0]  len1,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              serOut,
    output logic              serOutValid,
    output logic              busy,
    output logic              done
);

    state_t            state;
    logic [POS_W-1:0]  pos;       // frame bits already placed on serOut
    logic [CNT_W-1:0]  len_q;
    logic [DATA_W-1:0] data_q;
    logic              sel;       // latched winner: 0 or 1
    logic [1:0]        arb_gnt;
    logic              frame_end;

    assign frame_end = clkEn && (state != IDLE) && (pos == frame_bits(len_q));

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0),
        .req1   (req1),
        .update (frame_end),
        .last   (sel),
        .gnt    (arb_gnt)
    );

    // Frame sequencer: grant/latch on an idle tick, then one bit per tick until the frame is exhausted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pos         <= '0;
            len_q       <= '0;
            data_q      <= '0;
            sel         <= 1'b0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            serOut      <= 1'b0;
            serOutValid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            done <= 1'b0;
            if (clkEn) begin
                case (state)
                    IDLE: begin
                        if (arb_gnt != 2'b00) begin
                            sel         <= arb_gnt[1];
                            len_q       <= arb_gnt[1] ? len1 : len0;
                            data_q      <= arb_gnt[1] ? data1 : data0;
                            gnt0        <= arb_gnt[0];
                            gnt1        <= arb_gnt[1];
                            serOut      <= PREAMBLE[3];
                            serOutValid <= 1'b1;
                            busy        <= 1'b1;
                            pos         <= POS_W'(1);
                            state       <= PRE;
                        end
                    end
                    default: begin
                        if (frame_end) begin
                            state       <= IDLE;
                            pos         <= '0;
                            serOut      <= 1'b0;
                            serOutValid <= 1'b0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                        end else begin
                            pos <= pos + POS_W'(1);
                            if (pos < POS_W'(4)) begin
                                serOut <= PREAMBLE[2'(POS_W'(3) - pos)];
                                state  <= PRE;
                            end else if (pos < POS_W'(FRAME_OVH)) begin
                                serOut <= len_q[2'(POS_W'(7) - pos)];
                                state  <= CNT;
                            end else begin
                                serOut <= data_q[4'(pos - POS_W'(FRAME_OVH))];
                                state  <= DATA;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_scheduler.sv
// Bench for serial_frame_scheduler: queue-based frame model checked every clock, plus literal frame checks.
module tb_serial_frame_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clkEn = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [3:0]  len0 = '0, len1 = '0;
    logic [14:0] data0 = '0, data1 = '0;
    logic        gnt0, gnt1, serOut, serOutValid, busy, done;

    int n_chk  = 0;
    int n_pass = 0;

    serial_frame_scheduler dut (
        .clk(clk), .rst(rst), .clkEn(clkEn),
        .req0(req0), .len0(len0), .data0(data0),
        .req1(req1), .len1(len1), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .serOut(serOut), .serOutValid(serOutValid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model: a frame is just a queue of bits ----------------
    bit mq[$];
    bit m_busy = 0, m_ser = 0, m_vld = 0, m_done = 0, m_g0 = 0, m_g1 = 0, m_ptr = 0;
    int m_win = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_busy = 0; m_ser = 0; m_vld = 0; m_done = 0; m_g0 = 0; m_g1 = 0; m_ptr = 0; m_win = 0;
        end else begin
            m_g0 = 0; m_g1 = 0; m_done = 0;
            if (clkEn) begin
                if (!m_busy) begin
                    if (req0 || req1) begin
                        logic [3:0]  l;
                        logic [14:0] d;
                        m_win = (req0 && req1) ? int'(m_ptr) : (req1 ? 1 : 0);
                        l = (m_win == 1) ? len1 : len0;
                        d = (m_win == 1) ? data1 : data0;
                        mq.delete();
                        mq.push_back(1); mq.push_back(1); mq.push_back(0); mq.push_back(1);
                        for (int i = 3; i >= 0; i--) mq.push_back(l[i]);
                        for (int i = 0; i < int'(l); i++) mq.push_back(d[i]);
                        m_g0 = (m_win == 0); m_g1 = (m_win == 1);
                        m_busy = 1; m_vld = 1; m_ser = mq.pop_front();
                    end
                end else if (mq.size() == 0) begin
                    m_busy = 0; m_vld = 0; m_ser = 0; m_done = 1;
                    m_ptr = (m_win == 0);
                end else begin
                    m_ser = mq.pop_front();
                end
            end
        end
    end

    // Every clock, away from the active edge, the DUT must agree with the model.
    always @(negedge clk) begin
        chk("gnt0", gnt0, m_g0);
        chk("gnt1", gnt1, m_g1);
        chk("serOut", serOut, m_ser);
        chk("serOutValid", serOutValid, m_vld);
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input bit en);
        clkEn = en;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; clkEn = 0; req0 = 0; req1 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_serOut", serOut, 0);
        chk("rst_valid", serOutValid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_gnt", {gnt1, gnt0}, 0);
        rst = 0;
    endtask

    // Runs until done is seen (bounded), collecting the valid bits of the frame.
    task automatic run_frame(input bit toggle_en, input bit drop_req,
                             output logic [31:0] word, output int nbits, output int done_tick,
                             output int gnt_id, output int gnt_tick, output int holds_bad);
        int t;
        bit en;
        logic p_ser, p_vld, p_busy;
        word = 0; nbits = 0; done_tick = -1; gnt_id = -1; gnt_tick = -1; t = 0; holds_bad = 0;
        for (int c = 0; c < 400; c++) begin
            en = toggle_en ? (c % 2 == 0) : 1'b1;
            p_ser = serOut; p_vld = serOutValid; p_busy = busy;
            step(en);
            if (en) t++;
            else if (serOut !== p_ser || serOutValid !== p_vld || busy !== p_busy) holds_bad++;
            if (gnt0 === 1'b1 && gnt_id < 0) begin gnt_id = 0; gnt_tick = t; if (drop_req) req0 = 0; end
            if (gnt1 === 1'b1 && gnt_id < 0) begin gnt_id = 1; gnt_tick = t; if (drop_req) req1 = 0; end
            if (en && serOutValid === 1'b1) begin word = {word[30:0], serOut}; nbits++; end
            if (done === 1'b1) begin done_tick = t; break; end
        end
    endtask

    logic [31:0] w;
    int nb, dt, gi, gt, hb;

    initial begin
        do_reset();

        // 1: single len=3 frame from requester 0
        req0 = 1; len0 = 4'd3; data0 = 15'b101;
        run_frame(0, 1, w, nb, dt, gi, gt, hb);
        chk("t1_bits", w, 32'b1101_0011_101);
        chk("t1_nbits", nb, 11);
        chk("t1_done_tick", dt, 12);
        chk("t1_gnt_id", gi, 0);

        // 2: both request; 0 first, then 1 on the tick after done, then back to 0
        do_reset();
        req0 = 1; req1 = 1; len0 = 4'd1; data0 = 15'h1; len1 = 4'd2; data1 = 15'b10;
        run_frame(0, 1, w, nb, dt, gi, gt, hb);
        chk("t2a_gnt_id", gi, 0);
        chk("t2a_bits", w, 32'b1101_0001_1);
        chk("t2a_done_tick", dt, 10);
        run_frame(0, 1, w, nb, dt, gi, gt, hb);
        chk("t2b_gnt_id", gi, 1);
        chk("t2b_gnt_tick", gt, 1);
        chk("t2b_bits", w, 32'b1101_0010_01);
        chk("t2b_nbits", nb, 10);
        req0 = 1; req1 = 1;
        run_frame(0, 1, w, nb, dt, gi, gt, hb);
        chk("t2c_gnt_id", gi, 0);

        // 3: zero-length frame from requester 1
        do_reset();
        req1 = 1; len1 = 4'd0; data1 = 15'h7FFF;
        run_frame(0, 1, w, nb, dt, gi, gt, hb);
        chk("t3_bits", w, 32'b1101_0000);
        chk("t3_nbits", nb, 8);
        chk("t3_done_tick", dt, 9);
        chk("t3_gnt_id", gi, 1);

        // 4: longest frame with clkEn toggling every clock
        do_reset();
        req0 = 1; len0 = 4'd15; data0 = 15'h7FFF;
        run_frame(1, 1, w, nb, dt, gi, gt, hb);
        chk("t4_bits", w, 32'b1101_1111_1111_1111_1111_111);
        chk("t4_nbits", nb, 23);
        chk("t4_done_tick", dt, 24);
        chk("t4_hold", hb, 0);

        // 5: async reset during DATA bit 2 of a len=5 frame
        do_reset();
        req0 = 1; len0 = 4'd5; data0 = 15'b10101;
        repeat (10) step(1);
        chk("t5_mid_valid", serOutValid, 1);
        #1 rst = 1;
        #1;
        chk("t5_rst_serOut", serOut, 0);
        chk("t5_rst_valid", serOutValid, 0);
        chk("t5_rst_busy", busy, 0);
        @(posedge clk);
        #1 rst = 0;
        run_frame(0, 1, w, nb, dt, gi, gt, hb);
        chk("t5_fresh_bits", w, 32'b1101_0101_10101);
        chk("t5_fresh_gnt", gi, 0);

        // 6: both requests held continuously -> strict alternation, one idle tick between frames
        do_reset();
        req0 = 1; req1 = 1; len0 = 4'd2; len1 = 4'd1;
        data0 = 15'($urandom); data1 = 15'($urandom);
        for (int f = 0; f < 4; f++) begin
            run_frame(0, 0, w, nb, dt, gi, gt, hb);
            chk("t6_alt", gi, f % 2);
            chk("t6_done_tick", dt, (f % 2 == 0) ? 11 : 10);
            if (f > 0) chk("t6_gap", gt, 1);
        end

        // Random phase: model comparison runs every clock
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            req0  = ($urandom_range(0, 3) != 0);
            req1  = ($urandom_range(0, 2) != 0);
            len0  = 4'($urandom); len1 = 4'($urandom);
            data0 = 15'($urandom); data1 = 15'($urandom);
            step($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) begin
                rst = 1;
                #2 rst = 0;
            end
        end

        step(0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/serial_frame_scheduler.md
Name: serial_frame_scheduler

Overview:
- Two-requester round-robin scheduler and framer that sequences the serial input of the sequence detector.
- Accepts parallel payload requests, grants one at a time, and emits a frame of 4-bit preamble (1101), a 4-bit count, then count payload bits.
- Each bit advances on clock edges where clkEn=1, so it shares the detector's bit-rate enable.
- Sits directly upstream of the detector; serOut drives the detector's serIn.

Parameters:
- PREAMBLE, 4'b1101, start pattern sent MSB first.
- CNT_W, 4, width of the length field.
- DATA_W, 15, payload register width; must equal 2^CNT_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clkEn  input  1  bit-tick enable; state and serial outputs move only on clk edges with clkEn=1.
- req0  input  1  requester 0 frame request (level, held until gnt0).
- len0  input  CNT_W  requester 0 payload length, 0..15.
- data0  input  DATA_W  requester 0 payload, bit 0 sent first.
- req1  input  1  requester 1 request.
- len1  input  CNT_W  requester 1 length.
- data1  input  DATA_W  requester 1 payload.
- gnt0  output  1  one-clk pulse: requester 0 latched.
- gnt1  output  1  one-clk pulse: requester 1 latched.
- serOut  output  1  serial frame bit (to detector serIn).
- serOutValid  output  1  high while a frame bit is on serOut.
- busy  output  1  high from grant to end of frame.
- done  output  1  one-clk pulse at frame end.

Behaviour:
- Reset (async, immediate, including mid-frame): state IDLE; serOut=0, serOutValid=0, busy=0, done=0, gnt0=gnt1=0; priority pointer=requester 0; bit counter=0. No partial frame resumes.
- States: IDLE, PRE, CNT, DATA. All transitions occur only on edges with clkEn=1. gnt and done are one clk cycle wide, not one tick.
- IDLE on tick with any req:
  - If both request, the pointer picks the winner.
  - Latch the winner's len and data; pulse its gnt.
  - Set busy=1, serOutValid=1, serOut=PREAMBLE[3]; enter PRE. This tick is frame bit 1.
- PRE: the next 3 ticks output PREAMBLE[2], [1], [0]. The tick after [0] outputs len[3] and enters CNT.
- CNT: ticks output len[2], [1], [0]. The tick after len[0] enters DATA with data[0] if len>0.
  - If len=0, that tick ends the frame instead.
- DATA: each tick outputs the next bit, LSB first, until len bits are sent.
- Frame end, on the tick following the last bit:
  - State IDLE; serOut=0, serOutValid=0, busy=0.
  - done pulses; pointer moves to the other requester.
- Frame duration: 8+len ticks. A new grant is possible no earlier than the next tick, which guarantees at least one idle bit (serOut=0) between frames.
- Requests while busy are ignored, not queued beyond the held level. A req that falls before grant is dropped silently.
- len/data changes after grant have no effect; values are latched at grant.
- clkEn=0 freezes all state and outputs, except that gnt and done still drop after one clk.

Decomposition:
- Shared package holds:
  - state enum {IDLE, PRE, CNT, DATA};
  - PREAMBLE, CNT_W, DATA_W constants;
  - the frame-length formula constant FRAME_OVH=8.
- One natural sub-module, rr_arbiter2: two requests plus pointer in, one-hot grant out, pointer update on done.
- The framer shift/counter logic stays in the top.

Test Plan:
1. Reset, then req0=1, len0=3, data0=15'b101 -> gnt0 pulse; serOut over ticks 1,1,0,1,0,0,1,1,1,0,1; serOutValid high for exactly 11 ticks; done at tick 12; gnt1 never asserts.
2. req0 and req1 high together after reset, len0=1, len1=2 -> requester 0 framed first (9 ticks), then gnt1 on the next tick after done; second frame is 10 ticks; pointer returns to 0.
3. len1=0, req1 only -> serOut 1,1,0,1,0,0,0,0; done on tick 9; no DATA state.
4. len0=15, data0=15'h7FFF, clkEn toggling every clk as in the detector bench -> 23 valid bits, payload all 1s; outputs hold during clkEn=0 clocks.
5. Assert rst during DATA bit 2 of a len=5 frame -> serOut, serOutValid and busy go 0 immediately without a clock; after release, the next held req starts a fresh frame with preamble.
6. Back-to-back requests from both sides held continuously -> strict alternation 0,1,0,1; exactly one idle tick between frames.
